// File: rtl/modn_cascade_pkg.sv
// Shared helpers for the modulo-N cascade counter: digit slicing, digit maxima,
// clog2 and count-direction encodings.
package modn_cascade_pkg;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // LSB position of digit idx inside a packed count/load vector.
  function automatic int unsigned digit_lsb(int unsigned idx, int unsigned dw);
    return idx * dw;
  endfunction

  function automatic int unsigned inner_max(int unsigned digit_mod);
    return digit_mod - 1;
  endfunction

  function automatic int unsigned top_max(int unsigned top_mod);
    return top_mod - 1;
  endfunction

  function automatic int unsigned clog2(int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/modn_digit.sv
// Single modulo-MOD digit with clear, clamped parallel load and up/down step.
module modn_digit #(
  parameter int unsigned MOD = 10,
  parameter int unsigned DW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          up,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_zero
);
  import modn_cascade_pkg::*;

  // One extra bit so MOD == 2^DW still compares correctly.
  localparam logic [DW:0]   ModW = (DW + 1)'(MOD);
  localparam logic [DW-1:0] MaxV = DW'(MOD - 1);

  logic [DW-1:0] load_clamped;

  assign at_max       = (q == MaxV);
  assign at_zero      = (q == '0);
  assign load_clamped = ({1'b0, d} >= ModW) ? MaxV : d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_clamped;
    end else if (step) begin
      if (up == UP) begin
        q <= at_max ? '0 : q + 1'b1;
      end else begin
        q <= at_zero ? MaxV : q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/modn_cascade_counter.sv
// Cascade of modulo-N digits with enable, up/down, clear, load and a registered wrap pulse.
// Optional prescaler on the enable path when MODN_CASCADE_PRESCALE_EN is defined.
module modn_cascade_counter #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned DIGIT_MOD  = 10,
  parameter int unsigned TOP_MOD    = 6,
  parameter int unsigned DW         = 4
`ifdef MODN_CASCADE_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE   = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     up,
  input  logic                     clr,
  input  logic                     load,
  input  logic [NUM_DIGITS*DW-1:0] load_val,
  output logic [NUM_DIGITS*DW-1:0] count,
  output logic                     wrap_o,
  output logic                     tc_o
);
  import modn_cascade_pkg::*;

  logic                  cnt_en;
  logic [NUM_DIGITS-1:0] step;
  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_zero;
  logic [NUM_DIGITS-1:0] hit;
  logic                  wrap_q;

`ifdef MODN_CASCADE_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;

  logic [PsW-1:0] ps_q;
  logic           ps_hit;

  assign ps_hit = (ps_q == PsW'(PRESCALE - 1));
  assign cnt_en = en & ps_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q <= '0;
    end else if (clr || load) begin
      ps_q <= '0;
    end else if (en) begin
      ps_q <= ps_hit ? '0 : ps_q + 1'b1;
    end
  end
`else
  assign cnt_en = en;
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int unsigned Mod = (i == NUM_DIGITS - 1) ? top_max(TOP_MOD) + 1
                                                        : inner_max(DIGIT_MOD) + 1;

    assign hit[i] = (up == UP) ? at_max[i] : at_zero[i];

    // Digit i steps when every lower digit is at its roll-over value.
    if (i == 0) begin : g_lsd
      assign step[i] = cnt_en;
    end else begin : g_upper
      assign step[i] = cnt_en & (&hit[i-1:0]);
    end

    modn_digit #(
      .MOD(Mod),
      .DW (DW)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step[i]),
      .up     (up),
      .clr    (clr),
      .load   (load),
      .d      (load_val[digit_lsb(i, DW) +: DW]),
      .q      (count[digit_lsb(i, DW) +: DW]),
      .at_max (at_max[i]),
      .at_zero(at_zero[i])
    );
  end

  assign tc_o = cnt_en & (&hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else if (clr || load) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc_o;
    end
  end

  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Self-checking bench for modn_cascade_counter (default build, 2 digits mod 10 / mod 6).
module tb_modn_cascade_counter;
  localparam int ND = 2;
  localparam int DM = 10;
  localparam int TM = 6;
  localparam int DW = 4;
  localparam int W  = ND * DW;
  localparam int M  = DM ** (ND - 1) * TM;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en, up, clr, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         wrap_o, tc_o;

  int   compared   = 0;
  int   mismatched = 0;
  int   mv         = 0;
  logic mw         = 1'b0;
  logic started    = 1'b0;
  int   nwrap, ntc;

  always #5 clk = ~clk;

  modn_cascade_counter #(
    .NUM_DIGITS(ND),
    .DIGIT_MOD (DM),
    .TOP_MOD   (TM),
    .DW        (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .wrap_o  (wrap_o),
    .tc_o    (tc_o)
  );

  function automatic int digit_mod(int i);
    return (i == ND - 1) ? TM : DM;
  endfunction

  // Integer value -> packed digits.
  function automatic logic [W-1:0] pack(int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*DW +: DW] = DW'(x % digit_mod(i));
      x = x / digit_mod(i);
    end
    return r;
  endfunction

  // Packed load value -> integer value with each digit clamped to its modulus.
  function automatic int clamp_value(logic [W-1:0] lv);
    int v, wt, d;
    v  = 0;
    wt = 1;
    for (int i = 0; i < ND; i++) begin
      d = int'(lv[i*DW +: DW]);
      if (d >= digit_mod(i)) d = digit_mod(i) - 1;
      v  += d * wt;
      wt *= digit_mod(i);
    end
    return v;
  endfunction

  // Model: the counter is just an integer modulo M.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv <= 0;
      mw <= 1'b0;
    end else if (clr) begin
      mv <= 0;
      mw <= 1'b0;
    end else if (load) begin
      mv <= clamp_value(load_val);
      mw <= 1'b0;
    end else if (en) begin
      if (up) begin
        mv <= (mv + 1) % M;
        mw <= (mv == M - 1);
      end else begin
        mv <= (mv == 0) ? M - 1 : mv - 1;
        mw <= (mv == 0);
      end
    end else begin
      mw <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("model_count", 32'(count), 32'(pack(mv)));
      chk("model_wrap", 32'(wrap_o), 32'(mw));
      chk("model_tc", 32'(tc_o), 32'(en & (up ? (mv == M - 1) : (mv == 0))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;

    // Async reset between edges from 0x37, then first count.
    load = 1'b1; load_val = 8'h37;
    tick();
    load = 1'b0;
    chk("load_37", 32'(count), 32'h37);
    #2 rst = 1'b1;
    #1;
    chk("rst_count_async", 32'(count), 32'h00);
    chk("rst_wrap_async", 32'(wrap_o), 32'h0);
    #2 rst = 1'b0;
    en = 1'b1; up = 1'b1;
    tick();
    chk("first_en", 32'(count), 32'h01);

    // Full up cycle of 60 edges.
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr", 32'(count), 32'h00);
    en = 1'b1; up = 1'b1; nwrap = 0; ntc = 0;
    for (int i = 1; i < 60; i++) begin
      tick();
      if (wrap_o) nwrap++;
      if (tc_o) ntc++;
    end
    chk("up_59", 32'(count), 32'h59);
    chk("tc_at_59", 32'(tc_o), 32'h1);
    tick();
    if (wrap_o) nwrap++;
    if (tc_o) ntc++;
    chk("up_wrap_count", 32'(count), 32'h00);
    chk("up_wrap_pulse", 32'(wrap_o), 32'h1);
    chk("wrap_pulses_60", 32'(nwrap), 32'd1);
    chk("tc_cycles_60", 32'(ntc), 32'd1);
    en = 1'b0;
    tick();
    chk("wrap_single", 32'(wrap_o), 32'h0);
    chk("hold_0", 32'(count), 32'h00);

    // Down from zero.
    en = 1'b1; up = 1'b0;
    tick();
    chk("down_wrap_count", 32'(count), 32'h59);
    chk("down_wrap_pulse", 32'(wrap_o), 32'h1);
    tick();
    chk("down_58", 32'(count), 32'h58);
    chk("down_58_wrap", 32'(wrap_o), 32'h0);

    // Direction change at terminal count.
    en = 1'b0; load = 1'b1; load_val = 8'h59;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1 chk("tc_up_59", 32'(tc_o), 32'h1);
    up = 1'b0;
    #1 chk("tc_down_59", 32'(tc_o), 32'h0);
    tick();
    chk("toggle_58", 32'(count), 32'h58);
    chk("toggle_no_wrap", 32'(wrap_o), 32'h0);

    // Clamped load, then wrap up.
    en = 1'b0; load = 1'b1; load_val = 8'h7C;
    tick();
    load = 1'b0;
    chk("load_7c_clamp", 32'(count), 32'h59);
    chk("load_wrap0", 32'(wrap_o), 32'h0);
    en = 1'b1; up = 1'b1;
    tick();
    chk("load_then_wrap", 32'(count), 32'h00);
    chk("load_then_wrap_pulse", 32'(wrap_o), 32'h1);

    // Reset during wrap pulse.
    en = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_mid_pulse", 32'(wrap_o), 32'h0);
    #2 rst = 1'b0;

    // More clamping patterns.
    load = 1'b1; load_val = 8'h0F;
    tick();
    chk("load_0f_clamp", 32'(count), 32'h09);
    load_val = 8'h5A;
    tick();
    chk("load_5a_clamp", 32'(count), 32'h59);
    load = 1'b0;

    // clr beats load and en at terminal count.
    clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h37;
    tick();
    clr = 1'b0; load = 1'b0; en = 1'b0;
    chk("clr_priority", 32'(count), 32'h00);
    chk("clr_priority_wrap", 32'(wrap_o), 32'h0);

    // Hold, then a down run across a digit borrow.
    repeat (3) tick();
    chk("hold_3", 32'(count), 32'h00);
    en = 1'b1; up = 1'b0;
    repeat (15) tick();
    chk("down_15", 32'(count), 32'h45);
    en = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
